bcd_serial_deserializer: RTL and testbench

Upstream feeder for the BCD-to-excess-3 converter. It receives BCD digits as a serial bit stream, LSB first, with a valid/ready handshake. It assembles each group of 4 bits into a parallel digit, flags codes above 9, and presents the digit on a registered valid/ready output port. That port drives the converter's 4-bit input.

---
 rtl/bcd_serial_deserializer.sv | 103 ++++++++++
 tb/tb_bcd_serial_deserializer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcd_serial_deserializer.sv
// Serial-to-parallel BCD digit assembler: LSB-first bits in, one 4-bit digit
// out on a registered valid/ready port, with invalid-code and framing pulses.
module bcd_serial_deserializer #(
  parameter bit DROP_INVALID = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_first,
  output logic       in_ready,
  output logic [3:0] out_digit,
  output logic       out_valid,
  output logic       out_err,
  input  logic       out_ready,
  output logic       dig_err,
  output logic       frame_err
);

  logic [1:0] cnt_q, cnt_d;
  logic [2:0] sh_q, sh_d;
  logic [3:0] out_digit_q, out_digit_d;
  logic       out_valid_q, out_valid_d;
  logic       out_err_q, out_err_d;
  logic       dig_err_q, dig_err_d;
  logic       frame_err_q, frame_err_d;
  logic       accept;
  logic [3:0] digit;

  // Only the completing bit is back-pressured; bits 0-2 land in the shift
  // register regardless of the output stall.
  assign in_ready = !(cnt_q == 2'd3 && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign digit    = {in_bit, sh_q};

  always_comb begin
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    out_digit_d = out_digit_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    dig_err_d   = 1'b0;
    frame_err_d = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (in_first && cnt_q != 2'd0) begin
        frame_err_d = 1'b1;
        sh_d        = {2'b00, in_bit};
        cnt_d       = 2'd1;
      end else if (cnt_q == 2'd3) begin
        cnt_d = 2'd0;
        if (digit > 4'd9) begin
          dig_err_d = 1'b1;
          if (!DROP_INVALID) begin
            out_digit_d = digit;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
          end
        end else begin
          out_digit_d = digit;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
        end
      end else begin
        case (cnt_q)
          2'd0:    sh_d[0] = in_bit;
          2'd1:    sh_d[1] = in_bit;
          default: sh_d[2] = in_bit;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sh_q        <= '0;
      out_digit_q <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      dig_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_digit_q <= out_digit_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      dig_err_q   <= dig_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_digit = out_digit_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign dig_err   = dig_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bcd_serial_deserializer.sv
// Directed bench for bcd_serial_deserializer; a second instance covers the
// drop-invalid configuration on the same stimulus.
module tb_bcd_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_bit, in_first, out_ready;
  logic       in_ready, out_valid, out_err, dig_err, frame_err;
  logic [3:0] out_digit;
  logic       in_ready1, out_valid1, out_err1, dig_err1, frame_err1;
  logic [3:0] out_digit1;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  bcd_serial_deserializer #(.DROP_INVALID(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_first(in_first), .in_ready(in_ready), .out_digit(out_digit),
    .out_valid(out_valid), .out_err(out_err), .out_ready(out_ready),
    .dig_err(dig_err), .frame_err(frame_err)
  );

  bcd_serial_deserializer #(.DROP_INVALID(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_first(in_first), .in_ready(in_ready1), .out_digit(out_digit1),
    .out_valid(out_valid1), .out_err(out_err1), .out_ready(out_ready),
    .dig_err(dig_err1), .frame_err(frame_err1)
  );

  always @(posedge clk) if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;

  task automatic send_bit(input logic b, input logic f);
    in_valid = 1'b1; in_bit = b; in_first = f;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_first = 1'b1; out_ready = 1'b1;
    idle(); idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_digit !== 4'd0) begin errors++; $display("FAIL reset_digit got=%h exp=0", out_digit); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({dig_err, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {dig_err, frame_err}); end
    rst = 1'b0; in_valid = 1'b0; in_first = 1'b0;
    // digit 6 without in_first: first bit after reset is bit0
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd6) begin errors++; $display("FAIL reset_first_digit got=%b/%h exp=1/6", out_valid, out_digit); end
    idle();
  endtask

  task automatic test_stream();
    int hs0;
    logic [3:0] d;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      d = 4'(i);
      send_bit(d[0], 1'b1); send_bit(d[1], 1'b0); send_bit(d[2], 1'b0); send_bit(d[3], 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_digit !== d || out_err !== 1'b0) begin
        errors++; $display("FAIL stream_digit%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, out_digit, out_err, d);
      end
    end
    idle();
    checks++; if (hs_cnt - hs0 !== 10) begin errors++; $display("FAIL stream_handshakes got=%0d exp=10", hs_cnt - hs0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'hC || out_err !== 1'b1) begin
      errors++; $display("FAIL invalid_keep got=%b/%h/%b exp=1/c/1", out_valid, out_digit, out_err); end
    checks++; if (dig_err !== 1'b1) begin errors++; $display("FAIL invalid_dig_err got=%b exp=1", dig_err); end
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL invalid_drop_valid got=%b exp=0", out_valid1); end
    checks++; if (dig_err1 !== 1'b1) begin errors++; $display("FAIL invalid_drop_dig_err got=%b exp=1", dig_err1); end
    idle();
    checks++; if ({dig_err, dig_err1} !== 2'b00) begin errors++; $display("FAIL invalid_pulse_width got=%b exp=00", {dig_err, dig_err1}); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low got=%b exp=0", in_ready); end
    in_valid = 1'b1; in_bit = 1'b0;
    idle(); idle();
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd5) begin errors++; $display("FAIL bp_hold got=%b/%h exp=1/5", out_valid, out_digit); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_stalled got=%b exp=0", in_ready); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got=%b exp=1", in_ready); end
    idle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd3) begin errors++; $display("FAIL bp_new_digit got=%b/%h exp=1/3", out_valid, out_digit); end
    idle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drained got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_resync();
    int hs0;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL resync_frame_err got=%b exp=1", frame_err); end
    send_bit(1'b0, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL resync_pulse_width got=%b exp=0", frame_err); end
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd9 || out_err !== 1'b0) begin
      errors++; $display("FAIL resync_digit got=%b/%h/%b exp=1/9/0", out_valid, out_digit, out_err); end
    idle();
    checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL resync_one_digit got=%0d exp=1", hs_cnt - hs0); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd2) begin errors++; $display("FAIL midrst_pending got=%b/%h exp=1/2", out_valid, out_digit); end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || {dig_err, frame_err} !== 2'b00) begin
      errors++; $display("FAIL midrst_cleared got=%b/%b exp=0/00", out_valid, {dig_err, frame_err}); end
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_digit !== 4'd8 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_fresh got=%b/%h/%b exp=1/8/0", out_valid, out_digit, frame_err); end
    idle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_invalid();
    test_backpressure();
    test_resync();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
